// File: rtl/canny_accel_acc_round_sat.sv
// Sums TAPS unsigned multiplier products per pixel, round-shifts and saturates the sum,
// and hands pixels downstream through a 2-entry valid/ready buffer with backpressure.
module canny_accel_acc_round_sat #(
    parameter int P_W   = 27,
    parameter int TAPS  = 3,
    parameter int SHIFT = 11,
    parameter int ROUND = 1,
    parameter int OUT_W = 8,
    parameter int ACC_W = P_W + 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             clr,
    input  logic [P_W-1:0]   p_data,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             sat_flag,
    output logic             busy
);

    localparam logic [1:0]     LAST_TAP = 2'(TAPS - 1);
    localparam logic [ACC_W:0] RND_BIAS = (ROUND != 0) ? ((ACC_W+1)'(1) << (SHIFT - 1)) : '0;
    localparam logic [ACC_W:0] PIX_MAX  = (ACC_W+1)'((1 << OUT_W) - 1);

    // One guard bit above the sum so the rounding bias can never wrap.
    function automatic logic [ACC_W:0] round_shift(input logic [ACC_W-1:0] sum);
        logic [ACC_W:0] v;
        v = {1'b0, sum} + RND_BIAS;
        return v >> SHIFT;
    endfunction

    // Returns {clamped, pixel}.
    function automatic logic [OUT_W:0] saturate(input logic [ACC_W:0] r);
        if (r > PIX_MAX)
            return {1'b1, {OUT_W{1'b1}}};
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    logic [1:0]       r_tap_cnt_p0;
    logic [ACC_W-1:0] r_acc_p0;
    logic [OUT_W-1:0] r_head_p1;
    logic [OUT_W-1:0] r_tail_p1;
    logic [1:0]       r_count_p1;
    logic             r_sat_p1;

    logic             w_accept;
    logic             w_last;
    logic             w_pop;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W:0]   w_rs;
    logic [OUT_W:0]   w_sat_pix;

    assign p_ready   = (r_count_p1 != 2'd2);
    assign w_accept  = p_valid && p_ready && !clr;
    assign w_last    = w_accept && (r_tap_cnt_p0 == LAST_TAP);
    assign w_pop     = (r_count_p1 != 2'd0) && m_ready;
    assign w_sum     = ((r_tap_cnt_p0 == 2'd0) ? '0 : r_acc_p0) + ACC_W'(p_data);
    assign w_rs      = round_shift(w_sum);
    assign w_sat_pix = saturate(w_rs);

    // Stage p0: tap counter and running sum
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_tap_cnt_p0 <= 2'd0;
            r_acc_p0     <= '0;
        end else if (clr) begin
            r_tap_cnt_p0 <= 2'd0;
            r_acc_p0     <= '0;
        end else if (w_accept) begin
            r_acc_p0     <= w_sum;
            r_tap_cnt_p0 <= w_last ? 2'd0 : r_tap_cnt_p0 + 2'd1;
        end
    end

    // Stage p1: output buffer head, occupancy and sticky saturation
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_head_p1  <= '0;
            r_count_p1 <= 2'd0;
            r_sat_p1   <= 1'b0;
        end else begin
            if (clr)
                r_sat_p1 <= 1'b0;
            else if (w_last && w_sat_pix[OUT_W])
                r_sat_p1 <= 1'b1;

            case ({w_last, w_pop})
                2'b10: begin
                    if (r_count_p1 == 2'd0)
                        r_head_p1 <= w_sat_pix[OUT_W-1:0];
                    r_count_p1 <= r_count_p1 + 2'd1;
                end
                2'b01: begin
                    r_head_p1  <= r_tail_p1;
                    r_count_p1 <= r_count_p1 - 2'd1;
                end
                2'b11: begin
                    r_head_p1 <= (r_count_p1 == 2'd1) ? w_sat_pix[OUT_W-1:0] : r_tail_p1;
                end
                default: ;
            endcase
        end
    end

    // The second slot is only ever read while occupied, so it needs no reset.
    always_ff @(posedge ap_clk) begin
        if (w_last && ((r_count_p1 == 2'd1 && !w_pop) || (r_count_p1 == 2'd2 && w_pop)))
            r_tail_p1 <= w_sat_pix[OUT_W-1:0];
    end

    assign m_data   = r_head_p1;
    assign m_valid  = (r_count_p1 != 2'd0);
    assign sat_flag = r_sat_p1;
    assign busy     = (r_tap_cnt_p0 != 2'd0) || (r_count_p1 != 2'd0);

endmodule

// File: tb/tb_canny_accel_acc_round_sat.sv
// Bench for canny_accel_acc_round_sat: directed and random streams against a queue-based
// model, run on a rounding and a truncating instance fed with identical stimulus.
module tb_canny_accel_acc_round_sat;

    localparam int P_W   = 27;
    localparam int TAPS  = 3;
    localparam int SHIFT = 11;
    localparam int OUT_W = 8;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic             clr;
    logic [P_W-1:0]   p_data;
    logic             p_valid;
    logic             m_ready;

    logic             p_ready1, m_valid1, sat1_o, busy1;
    logic [OUT_W-1:0] m_data1;
    logic             p_ready0, m_valid0, sat0_o, busy0;
    logic [OUT_W-1:0] m_data0;

    int checks   = 0;
    int failures = 0;

    longint unsigned partial[$];
    longint unsigned exp1[$];
    longint unsigned exp0[$];
    bit              sat1_m, sat0_m;

    always #5 ap_clk = ~ap_clk;

    canny_accel_acc_round_sat #(.P_W(P_W), .TAPS(TAPS), .SHIFT(SHIFT), .ROUND(1), .OUT_W(OUT_W)) dut_rnd (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr),
        .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
        .sat_flag(sat1_o), .busy(busy1)
    );

    canny_accel_acc_round_sat #(.P_W(P_W), .TAPS(TAPS), .SHIFT(SHIFT), .ROUND(0), .OUT_W(OUT_W)) dut_trn (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr),
        .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready0),
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready),
        .sat_flag(sat0_o), .busy(busy0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Plain arithmetic reference: divide by 2^SHIFT after optional half-LSB bias, clamp.
    function automatic longint unsigned ref_pix(input longint unsigned sum, input bit rnd, output bit sat);
        longint unsigned r;
        r   = (sum + (rnd ? (longint'(1) << (SHIFT - 1)) : 0)) / (longint'(1) << SHIFT);
        sat = (r > 255);
        return sat ? 255 : r;
    endfunction

    task automatic model_reset();
        partial.delete();
        exp1.delete();
        exp0.delete();
        sat1_m = 1'b0;
        sat0_m = 1'b0;
    endtask

    task automatic check_outputs();
        check("m_valid_rnd", m_valid1, exp1.size() != 0);
        check("m_valid_trn", m_valid0, exp0.size() != 0);
        if (exp1.size() != 0) check("m_data_rnd", m_data1, exp1[0]);
        if (exp0.size() != 0) check("m_data_trn", m_data0, exp0[0]);
        check("p_ready_rnd", p_ready1, exp1.size() < 2);
        check("p_ready_trn", p_ready0, exp0.size() < 2);
        check("sat_rnd", sat1_o, sat1_m);
        check("sat_trn", sat0_o, sat0_m);
        check("busy_rnd", busy1, (partial.size() != 0) || (exp1.size() != 0));
    endtask

    // One clock: predict from current inputs, advance, then compare.
    task automatic cycle(output bit accepted);
        longint unsigned sum;
        bit              s;
        accepted = p_valid && (exp1.size() < 2) && !clr;
        if (m_ready && exp1.size() != 0) begin
            void'(exp1.pop_front());
            void'(exp0.pop_front());
        end
        if (clr) begin
            partial.delete();
            sat1_m = 1'b0;
            sat0_m = 1'b0;
        end else if (accepted) begin
            partial.push_back(longint'(p_data));
            if (partial.size() == TAPS) begin
                sum = 0;
                foreach (partial[i]) sum += partial[i];
                exp1.push_back(ref_pix(sum, 1'b1, s));
                if (s) sat1_m = 1'b1;
                exp0.push_back(ref_pix(sum, 1'b0, s));
                if (s) sat0_m = 1'b1;
                partial.delete();
            end
        end
        @(posedge ap_clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit a;
        p_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle(a);
    endtask

    task automatic send_beat(input longint unsigned d);
        bit a;
        bit got;
        got     = 1'b0;
        p_valid = 1'b1;
        p_data  = P_W'(d);
        for (int k = 0; k < 20 && !got; k++) begin
            cycle(a);
            got = a;
        end
        check("beat_accepted", got, 1'b1);
    endtask

    initial begin
        bit a;
        int pulses;

        ap_rst_n = 1'b0;
        clr      = 1'b0;
        p_valid  = 1'b0;
        p_data   = '0;
        m_ready  = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_m_valid", m_valid1, 1'b0);
        check("rst_m_data", m_data1, 0);
        check("rst_sat", sat1_o, 1'b0);
        check("rst_busy", busy1, 1'b0);
        ap_rst_n = 1'b1;
        idle(2);

        // Rounded vs truncated pixel
        send_beat(61200);
        send_beat(180300);
        send_beat(46600);
        check("t1_pix_round", m_data1, 141);
        check("t2_pix_trunc", m_data0, 140);
        check("t1_sat", sat1_o, 1'b0);
        idle(3);

        // Saturation is sticky until clr
        send_beat(40107420);
        send_beat(78774070);
        send_beat(15268655);
        check("t3_pix_sat", m_data1, 255);
        check("t3_sat_set", sat1_o, 1'b1);
        send_beat(61200);
        send_beat(180300);
        send_beat(46600);
        check("t3_inrange_pix", m_data1, 141);
        check("t3_sat_sticky", sat1_o, 1'b1);
        p_valid = 1'b0;
        clr = 1'b1;
        cycle(a);
        clr = 1'b0;
        check("t3_sat_cleared", sat1_o, 1'b0);
        idle(3);

        // Backpressure: two pixels buffered, third pixel stalls
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_beat(10000 * (i + 1) + $urandom_range(0, 999));
        p_valid = 1'b1;
        p_data  = P_W'(77000);
        for (int k = 0; k < 4; k++) begin
            cycle(a);
            check("t4_stall_p_ready", p_ready1, 1'b0);
        end
        m_ready = 1'b1;
        send_beat(77000);
        send_beat(88000);
        send_beat(99000);
        idle(5);
        check("t4_drained", m_valid1, 1'b0);

        // Push and pop in the same cycle with one pixel buffered
        m_ready = 1'b0;
        send_beat(61200);
        send_beat(180300);
        send_beat(46600);
        send_beat(50000);
        send_beat(60000);
        m_ready = 1'b1;
        send_beat(70000);
        check("t5_pushpop_head", m_data1, 88);
        check("t5_pushpop_valid", m_valid1, 1'b1);
        idle(3);

        // Sustained throughput: one pixel per TAPS cycles
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            send_beat($urandom_range(0, 200000));
            if (m_valid1) pulses++;
        end
        check("t5_throughput", pulses, 10);
        idle(3);

        // Asynchronous reset mid-cycle with a buffered pixel and a partial sum
        m_ready = 1'b0;
        send_beat(61200);
        send_beat(180300);
        send_beat(46600);
        send_beat(9000000);
        send_beat(9000000);
        #3;
        ap_rst_n = 1'b0;
        p_valid  = 1'b0;
        #1;
        check("t6_arst_m_valid", m_valid1, 1'b0);
        check("t6_arst_m_data", m_data1, 0);
        check("t6_arst_busy", busy1, 1'b0);
        check("t6_arst_m_valid_trn", m_valid0, 1'b0);
        model_reset();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        m_ready  = 1'b1;
        idle(1);
        send_beat(50000);
        send_beat(60000);
        send_beat(70000);
        check("t6_fresh_pix", m_data1, 88);
        check("t6_fresh_pix_trn", m_data0, 87);
        idle(3);

        // clr mid-sum: partial dropped (same-cycle beat too), buffered pixel kept
        m_ready = 1'b0;
        send_beat(61200);
        send_beat(180300);
        send_beat(46600);
        send_beat(9000000);
        send_beat(9000000);
        p_valid = 1'b1;
        p_data  = P_W'(9000000);
        clr     = 1'b1;
        cycle(a);
        clr = 1'b0;
        check("t6_clr_keeps_pix", m_data1, 141);
        check("t6_clr_busy", busy1, 1'b1);
        m_ready = 1'b1;
        send_beat(50000);
        send_beat(60000);
        send_beat(70000);
        check("t6_clr_new_pix", m_data1, 88);
        idle(3);

        // Randomized traffic with random backpressure and occasional clr
        for (int i = 0; i < 300; i++) begin
            p_valid = 1'($urandom_range(0, 1));
            m_ready = ($urandom_range(0, 3) != 0);
            clr     = ($urandom_range(0, 39) == 0);
            p_data  = ($urandom_range(0, 9) == 0) ? P_W'($urandom_range(0, (1 << P_W) - 1))
                                                   : P_W'($urandom_range(0, 200000));
            cycle(a);
        end
        clr     = 1'b0;
        m_ready = 1'b1;
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
